// File: rtl/wallace_mac_pkg.sv
// Shared types and constants for the Wallace-tree multiply-accumulate sequencer.
package wallace_mac_pkg;

   localparam int OPER_W    = 8;
   localparam int PROD_W    = 16;
   localparam int ACC_W_DEF = 20;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/wallace_mac_acc.sv
// Accumulator register for the MAC sequencer; clamps to all ones and flags it
// when WALLACE_MAC_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_W.
module wallace_mac_acc
   import wallace_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [PROD_W-1:0] addend,
   output logic [ACC_W-1:0]  sum,
   output logic              sat
);

   logic [ACC_W-1:0] acc_reg;

`ifdef WALLACE_MAC_SATURATE_EN
   logic             sat_reg;
   logic [ACC_W:0]   sum_ext;

   // One extra bit exposes the carry out that signals overflow.
   assign sum_ext = {1'b0, acc_reg} + (ACC_W+1)'(addend);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         sat_reg <= 1'b0;
      end else if (clear) begin
         acc_reg <= '0;
         sat_reg <= 1'b0;
      end else if (enable) begin
         if (sum_ext[ACC_W]) begin
            acc_reg <= '1;
            sat_reg <= 1'b1;
         end else begin
            acc_reg <= sum_ext[ACC_W-1:0];
         end
      end
   end

   assign sat = sat_reg;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else if (clear) begin
         acc_reg <= '0;
      end else if (enable) begin
         acc_reg <= acc_reg + ACC_W'(addend);
      end
   end

   assign sat = 1'b0;
`endif

   assign sum = acc_reg;

endmodule

// File: rtl/wallace_mac_sequencer.sv
// Burst multiply-accumulate sequencer around an external combinational 8x8 multiplier.
// Optional saturation: define WALLACE_MAC_SATURATE_EN.
module wallace_mac_sequencer
   import wallace_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_terms,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPER_W-1:0] in_a,
   input  logic [OPER_W-1:0] in_b,
   output logic [OPER_W-1:0] mul_a,
   output logic [OPER_W-1:0] mul_b,
   input  logic [PROD_W-1:0] mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_sat
);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   remaining_reg, remaining_next;
   logic [OPER_W-1:0]  mul_a_reg, mul_a_next;
   logic [OPER_W-1:0]  mul_b_reg, mul_b_next;
   logic               mul_valid_reg, mul_valid_next;
   logic               acc_clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         mul_a_reg     <= '0;
         mul_b_reg     <= '0;
         mul_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         mul_a_reg     <= mul_a_next;
         mul_b_reg     <= mul_b_next;
         mul_valid_reg <= mul_valid_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      mul_a_next     = mul_a_reg;
      mul_b_next     = mul_b_reg;
      mul_valid_next = 1'b0;
      acc_clear      = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               acc_clear      = 1'b1;
               remaining_next = num_terms;
               state_next     = (num_terms == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // remaining is at least 1 here, so reaching 1 means this is the last pair.
            if (in_valid) begin
               mul_a_next     = in_a;
               mul_b_next     = in_b;
               mul_valid_next = 1'b1;
               remaining_next = remaining_reg - 1'b1;
               if (remaining_reg == CNT_W'(1)) state_next = DRAIN;
            end
         end
         DRAIN: state_next = DONE;
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   wallace_mac_acc #(.ACC_W(ACC_W)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (acc_clear),
      .enable (mul_valid_reg),
      .addend (mul_p),
      .sum    (out_acc),
      .sat    (out_sat)
   );

   assign busy      = (state_reg != IDLE);
   assign in_ready  = (state_reg == RUN);
   assign out_valid = (state_reg == DONE);
   assign mul_a     = mul_a_reg;
   assign mul_b     = mul_b_reg;

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Directed-vector bench for wallace_mac_sequencer with a behavioural multiplier;
// a second 16-bit-accumulator instance covers the overflow case.
module tb_wallace_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  num_terms;
   logic        in_valid;
   logic [7:0]  in_a, in_b;
   logic        out_ready;

   logic        busy, in_ready, out_valid, out_sat;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_p;
   logic [19:0] out_acc;

   logic        busy16, in_ready16, out_valid16, out_sat16;
   logic [7:0]  mul_a16, mul_b16;
   logic [15:0] mul_p16;
   logic [15:0] out_acc16;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   assign mul_p   = {8'b0, mul_a} * {8'b0, mul_b};
   assign mul_p16 = {8'b0, mul_a16} * {8'b0, mul_b16};

   wallace_mac_sequencer #(.ACC_W(20), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat)
   );

   wallace_mac_sequencer #(.ACC_W(16), .CNT_W(8)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .busy(busy16),
      .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a16), .mul_b(mul_b16), .mul_p(mul_p16),
      .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16), .out_sat(out_sat16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] n);
      start     = 1'b1;
      num_terms = n;
      tick();
      start     = 1'b0;
   endtask

   task automatic pair(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   // Expects DONE now: checks the result, completes the handshake, expects IDLE.
   task automatic finish_burst(input string tag, input logic [31:0] exp_acc);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_out_acc"}, 32'(out_acc), exp_acc);
      $display("burst %s: out_acc=%0d out_sat=%0d", tag, out_acc, out_sat);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_terms = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_mul_b", 32'(mul_b), 32'd0);
      check("rst_out_acc", 32'(out_acc), 32'd0);
      rst_n = 1'b1;
      tick();

      // Back-to-back burst: 6 + 20 + 65025
      do_start(8'd3);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a = 8'd2;   in_b = 8'd3;   tick();
      in_a = 8'd4;   in_b = 8'd5;   tick();
      in_a = 8'd255; in_b = 8'd255; tick();
      in_valid = 1'b0;
      check("b2b_drain_in_ready", 32'(in_ready), 32'd0);
      check("b2b_drain_out_valid", 32'(out_valid), 32'd0);
      tick();
      finish_burst("b2b", 32'd65051);
      check("b2b_hold_acc", 32'(out_acc), 32'd65051);
      check("b2b_hold_mul_a", 32'(mul_a), 32'd255);

      // Reset mid-burst, then a fresh 1-term burst
      do_start(8'd4);
      pair(8'd1, 8'd1);
      pair(8'd2, 8'd2);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_acc", 32'(out_acc), 32'd0);
      check("midrst_mul_a", 32'(mul_a), 32'd0);
      check("midrst_mul_b", 32'(mul_b), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      do_start(8'd1);
      pair(8'd3, 8'd5);
      tick();
      finish_burst("after_rst", 32'd15);

      // Bubbles and backpressure: 200 + 63
      do_start(8'd2);
      pair(8'd10, 8'd20);
      repeat (3) tick();
      check("bub_in_ready", 32'(in_ready), 32'd1);
      check("bub_partial_acc", 32'(out_acc), 32'd200);
      pair(8'd7, 8'd9);
      check("bub_drain_in_ready", 32'(in_ready), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_acc", 32'(out_acc), 32'd263);
         tick();
      end
      finish_burst("bubbles", 32'd263);

      // Zero-length burst
      do_start(8'd0);
      check("zero_busy", 32'(busy), 32'd1);
      finish_burst("zero", 32'd0);

      // start pulsed during RUN must not reload the count: 9 + 16
      do_start(8'd2);
      start = 1'b1; num_terms = 8'd9;
      in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; tick();
      start = 1'b0;
      in_a = 8'd4; in_b = 8'd4; tick();
      in_valid = 1'b0;
      check("ign_in_ready", 32'(in_ready), 32'd0);
      tick();
      finish_burst("ignored_start", 32'd25);

      // Overflow on the 16-bit instance
      do_start(8'd2);
      in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255;
      tick(); tick();
      in_valid = 1'b0;
      tick();
      check("ovf16_out_valid", 32'(out_valid16), 32'd1);
`ifdef WALLACE_MAC_SATURATE_EN
      check("ovf16_out_acc", 32'(out_acc16), 32'd65535);
      check("ovf16_out_sat", 32'(out_sat16), 32'd1);
`else
      check("ovf16_out_acc", 32'(out_acc16), 32'd64514);
      check("ovf16_out_sat", 32'(out_sat16), 32'd0);
`endif
      check("ovf20_out_sat", 32'(out_sat), 32'd0);
      finish_burst("overflow20", 32'd130050);

      // Maximum burst length
      do_start(8'd255);
      in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
      repeat (254) tick();
      check("max_in_ready_last", 32'(in_ready), 32'd1);
      tick();
      check("max_in_ready_drop", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();
      finish_burst("max", 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
